// File: rtl/div_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | div_unit : iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.       |
// | Optional DIV_FAST_PATH_EN sends divide-by-zero and signed overflow to DONE. |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  input  logic [1:0]            op_i,
  input  logic [DATA_WIDTH-1:0] dividend_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  ready_o,
  output logic                  busy_o
);

  localparam int              W           = DATA_WIDTH;
  localparam logic [5:0]      c_LAST_ITER = 6'(DATA_WIDTH - 1);
  localparam logic [W-1:0]    c_MIN_NEG   = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]    c_ALL_ONES  = {W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  logic [5:0]     r_cnt;
  logic           r_is_rem;
  logic           r_neg_q;
  logic           r_neg_r;
  logic           r_div_zero;
  logic           r_ovf;
  logic [W-1:0]   r_dividend;
  logic [W-1:0]   r_divisor;
  logic [W-1:0]   r_quo;
  logic [W-1:0]   r_rem;
  logic [W-1:0]   r_result;
  logic           r_ready;

  logic           w_signed;
  logic           w_neg_a;
  logic           w_neg_b;
  logic [W-1:0]   w_abs_a;
  logic [W-1:0]   w_abs_b;
  logic           w_div_zero;
  logic           w_ovf;
  logic [W:0]     w_shift;
  logic [W:0]     w_sub;
  logic           w_ge;
  logic           w_unused_sub_msb;
  logic [W-1:0]   w_quo;
  logic [W-1:0]   w_rem;
  logic [W-1:0]   w_result;

  assign w_signed   = ~op_i[0];
  assign w_neg_a    = w_signed & dividend_i[W-1];
  assign w_neg_b    = w_signed & divisor_i[W-1];
  assign w_abs_a    = w_neg_a ? -dividend_i : dividend_i;
  assign w_abs_b    = w_neg_b ? -divisor_i  : divisor_i;
  assign w_div_zero = (divisor_i == '0);
  assign w_ovf      = w_signed && (dividend_i == c_MIN_NEG) && (divisor_i == c_ALL_ONES);

  // Partial remainder is one bit wider than the operands so |0x80000000| never truncates.
  assign w_shift          = {r_rem, r_quo[W-1]};
  assign w_sub            = w_shift - {1'b0, r_divisor};
  assign w_ge             = (w_shift >= {1'b0, r_divisor});
  assign w_unused_sub_msb = w_sub[W];

  always_comb begin
    w_quo = r_neg_q ? -r_quo : r_quo;
    w_rem = r_neg_r ? -r_rem : r_rem;
    if (r_div_zero) begin
      w_quo = c_ALL_ONES;
      w_rem = r_dividend;
    end else if (r_ovf) begin
      w_quo = c_MIN_NEG;
      w_rem = '0;
    end
    w_result = r_is_rem ? w_rem : w_quo;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_is_rem   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
      r_ovf      <= 1'b0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_result   <= '0;
      r_ready    <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i && !annul_i) begin
            r_cnt      <= '0;
            r_is_rem   <= op_i[1];
            r_neg_q    <= w_neg_a ^ w_neg_b;
            r_neg_r    <= w_neg_a;
            r_div_zero <= w_div_zero;
            r_ovf      <= w_ovf;
            r_dividend <= dividend_i;
            r_divisor  <= w_abs_b;
            r_quo      <= w_abs_a;
            r_rem      <= '0;
`ifdef DIV_FAST_PATH_EN
            r_state    <= (w_div_zero || w_ovf) ? S_DONE : S_CALC;
`else
            r_state    <= S_CALC;
`endif
          end
        end
        S_CALC: begin
          if (annul_i) begin
            r_state <= S_IDLE;
          end else begin
            // Dividend bits shift out of r_quo as quotient bits shift in.
            r_rem <= w_ge ? w_sub[W-1:0] : w_shift[W-1:0];
            r_quo <= {r_quo[W-2:0], w_ge};
            r_cnt <= r_cnt + 6'd1;
            if (r_cnt == c_LAST_ITER) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (!annul_i) begin
            r_ready  <= 1'b1;
            r_result <= w_result;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;
  assign busy_o   = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_div_unit : directed self-checking bench for div_unit.                    |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module tb_div_unit;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;
  localparam int         LAT     = 33;
`ifdef DIV_FAST_PATH_EN
  localparam int         LAT_SP  = 1;
`else
  localparam int         LAT_SP  = 33;
`endif

  logic        clk;
  logic        rst_i;
  logic        start_i;
  logic        annul_i;
  logic [1:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [31:0] result_o;
  logic        ready_o;
  logic        busy_o;

  int n_total  = 0;
  int n_pass   = 0;
  int n_runs   = 0;
  int n_ready  = 0;
  int n_double = 0;
  logic prev_ready = 1'b0;
  logic [31:0] last_res = 32'd0;

  div_unit #(.DATA_WIDTH(32)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .annul_i    (annul_i),
    .op_i       (op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .busy_o     (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ready_o) n_ready++;
    if (ready_o && prev_ready) n_double++;
    prev_ready = ready_o;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issue one operation, then check busy, ready latency, result and result hold.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input bit hold,
                        input string tag);
    int  lat;
    bit  seen;
    lat  = 0;
    seen = 1'b0;
    @(negedge clk);
    op_i = op; dividend_i = a; divisor_i = b; start_i = 1'b1;
    @(posedge clk); #1;
    start_i    = hold;
    op_i       = ~op;
    dividend_i = $urandom;
    divisor_i  = $urandom;
    check({tag, "_busy"}, 32'(busy_o), 32'd1);
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (ready_o) begin
        seen    = 1'b1;
        lat     = k;
        start_i = 1'b0;
        break;
      end
    end
    start_i = 1'b0;
    n_runs++;
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, result_o, exp);
    @(posedge clk); #1;
    check({tag, "_rdy_low"}, 32'(ready_o), 32'd0);
    check({tag, "_hold"}, result_o, exp);
    last_res = exp;
  endtask

  initial begin
    int rdy_snap;
    rst_i = 1'b0; start_i = 1'b0; annul_i = 1'b0;
    op_i = 2'b00; dividend_i = 32'd0; divisor_i = 32'd0;
    #2;
    check("rst_result", result_o, 32'd0);
    check("rst_ready", 32'(ready_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    @(posedge clk); #2 rst_i = 1'b1;

    run_op(OP_DIVU, 32'd100,        32'd7,          32'd14,         LAT,    1'b0, "divu_100_7");
    run_op(OP_REMU, 32'd100,        32'd7,          32'd2,          LAT,    1'b0, "remu_100_7");
    run_op(OP_DIV,  32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   LAT,    1'b0, "div_m100_7");
    run_op(OP_REM,  32'hFFFFFF9C,   32'd7,          32'hFFFFFFFE,   LAT,    1'b0, "rem_m100_7");
    run_op(OP_REM,  32'd100,        32'hFFFFFFF9,   32'd2,          LAT,    1'b0, "rem_100_m7");
    run_op(OP_DIV,  32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   LAT,    1'b0, "div_7_m2");
    run_op(OP_DIV,  32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          LAT,    1'b0, "div_m7_m2");
    run_op(OP_DIVU, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   LAT,    1'b0, "divu_max_1");
    run_op(OP_DIVU, 32'h80000000,   32'hFFFFFFFF,   32'd0,          LAT,    1'b0, "divu_min_max");
    run_op(OP_REMU, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   LAT,    1'b0, "remu_min_max");
    run_op(OP_DIV,  32'hFFFFFFF0,   32'd0,          32'hFFFFFFFF,   LAT_SP, 1'b0, "div_by0");
    run_op(OP_REM,  32'hFFFFFFF0,   32'd0,          32'hFFFFFFF0,   LAT_SP, 1'b0, "rem_by0");
    run_op(OP_REMU, 32'd5,          32'd0,          32'd5,          LAT_SP, 1'b0, "remu_by0");
    run_op(OP_DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   LAT_SP, 1'b0, "div_ovf");
    run_op(OP_REM,  32'h80000000,   32'hFFFFFFFF,   32'd0,          LAT_SP, 1'b0, "rem_ovf");
    run_op(OP_DIVU, 32'd9,          32'd3,          32'd3,          LAT,    1'b1, "start_held");

    // Annul during CALC, then a fresh operation two cycles later.
    rdy_snap = n_ready;
    @(negedge clk);
    op_i = OP_DIVU; dividend_i = 32'd9; divisor_i = 32'd3; start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    repeat (10) @(posedge clk);
    #1 annul_i = 1'b1;
    @(posedge clk); #1 annul_i = 1'b0;
    check("annul_calc_busy", 32'(busy_o), 32'd0);
    check("annul_calc_res", result_o, last_res);
    @(posedge clk); #1;
    check("annul_calc_nopulse", 32'(n_ready - rdy_snap), 32'd0);
    run_op(OP_DIVU, 32'd8, 32'd2, 32'd4, LAT, 1'b0, "after_annul");

    // Annul while in DONE suppresses the pulse and keeps the old result.
    rdy_snap = n_ready;
    @(negedge clk);
    op_i = OP_DIVU; dividend_i = 32'd50; divisor_i = 32'd5; start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    check("done_busy", 32'(busy_o), 32'd1);
    annul_i = 1'b1;
    @(posedge clk); #1 annul_i = 1'b0;
    check("annul_done_busy", 32'(busy_o), 32'd0);
    @(posedge clk); #1;
    check("annul_done_res", result_o, last_res);
    check("annul_done_nopulse", 32'(n_ready - rdy_snap), 32'd0);

    // Start and annul together in IDLE: nothing captured.
    @(negedge clk);
    start_i = 1'b1; annul_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; annul_i = 1'b0;
    check("start_annul_idle", 32'(busy_o), 32'd0);

    // Reset in the middle of CALC with start held high.
    rdy_snap = n_ready;
    @(negedge clk);
    op_i = OP_DIVU; dividend_i = 32'd100; divisor_i = 32'd7; start_i = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #3 rst_i = 1'b0;
    #1;
    check("midrst_result", result_o, 32'd0);
    check("midrst_ready", 32'(ready_o), 32'd0);
    check("midrst_busy", 32'(busy_o), 32'd0);
    start_i = 1'b0;
    @(posedge clk); #2 rst_i = 1'b1;
    check("midrst_nopulse", 32'(n_ready - rdy_snap), 32'd0);
    run_op(OP_DIVU, 32'd8, 32'd2, 32'd4, LAT, 1'b0, "first_after_rst");

    repeat (3) @(posedge clk);
    #1;
    check("pulse_count", 32'(n_ready), 32'(n_runs));
    check("no_double_pulse", 32'(n_double), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 clk_i  input  1  core clock; all state changes on its rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-low.
REQ-004 start_i  input  1  request a divide; sampled only in IDLE.
REQ-005 annul_i  input  1  pipeline flush (jump or trap); abandons the current operation.
REQ-006 op_i  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 dividend_i  input  32  rs1 value; captured with start.
REQ-008 divisor_i  input  32  rs2 value; captured with start.
REQ-009 result_o  output  32  quotient or remainder per the captured op.
REQ-010 ready_o  output  1  one-cycle pulse; result_o is valid in this cycle.
REQ-011 busy_o  output  1  high in CALC and DONE; exe ORs it into its stall request to pipe_ctrl.

Function
REQ-012 FSM states SHALL be IDLE, CALC and DONE, with IDLE as the reset state.
REQ-013 IDLE transitions: start_i=1 and annul_i=0 latches op, dividend, divisor and sign flags, clears the iteration counter, and goes to CALC; otherwise the FSM stays in IDLE.
REQ-014 CALC SHALL run radix-2 restoring division on the magnitudes.
- One quotient bit per cycle.
- 6-bit counter, 32 iterations.
- After iteration 32 the FSM goes to DONE.
REQ-015 DONE SHALL assert ready_o for exactly one cycle, drive the final result, and return to IDLE.
REQ-016 Latency: start accepted at edge N gives ready_o high in the cycle after edge N+33; ready_o SHALL never be high in two consecutive cycles.
REQ-017 result_o SHALL hold its value from DONE until the next accepted start.
REQ-018 start_i SHALL be ignored while in CALC or DONE; captured operands are unaffected by input changes after the capture edge.
REQ-019 Signed ops (DIV/REM) SHALL divide the absolute values.
- Quotient is negated when the operand signs differ.
- Remainder takes the sign of the dividend.
REQ-020 Divisor zero SHALL override the computed result.
- DIV/DIVU: quotient 0xFFFFFFFF.
- REM/REMU: remainder equals the dividend.
REQ-021 Signed overflow (dividend 0x80000000, divisor 0xFFFFFFFF) SHALL give DIV 0x80000000 and REM 0x00000000.
REQ-022 annul_i=1 in CALC or DONE SHALL return the FSM to IDLE at the next edge.
- No ready_o pulse is produced.
- result_o is unchanged.
REQ-023 annul_i and start_i both high in IDLE: annul wins and nothing is captured.
REQ-024 Arithmetic SHALL use a 33-bit partial remainder, so there is no overflow or truncation for any 32-bit magnitude, including |0x80000000|.

Reset
REQ-025 While rst_i=0 the block SHALL immediately force:
- state IDLE;
- result_o 0;
- ready_o 0;
- busy_o 0;
- counter 0;
- internal registers 0.
REQ-026 Reset asserted mid-operation SHALL discard the operation with no ready_o pulse.
REQ-027 After rst_i deasserts, a start may be accepted at the first rising edge.

Configuration
REQ-028 The macro DIV_FAST_PATH_EN SHALL select special-case handling.
- Defined: divisor zero and signed overflow skip CALC, going IDLE to DONE, so ready_o arrives in the cycle after the capture edge.
- Undefined: those cases take the full REQ-016 latency.
- Results SHALL be identical either way.

Verification
REQ-029 DIVU 100/7 -> ready_o after 33 edges, result 14; REMU 100/7 -> 2.
REQ-030 DIV 0xFFFFFF9C(-100)/7 -> 0xFFFFFFF2(-14); REM -> 0xFFFFFFFE(-2); REM 100/-7 -> 2.
REQ-031 Divisor 0, DIV dividend 0xFFFFFFF0 -> quotient 0xFFFFFFFF, REM -> 0xFFFFFFF0; latency 1 cycle with DIV_FAST_PATH_EN, 33 cycles without.
REQ-032 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
REQ-033 Start DIVU 9/3, annul_i at CALC cycle 10, start DIVU 8/2 two cycles later -> no pulse for the first op; one pulse with result 4.
REQ-034 Reset mid-CALC and start_i held high while busy -> outputs 0 immediately, no stray ready_o, and second starts are ignored while busy.
